// File: rtl/flappy_pkg.sv
// Shared playfield geometry defaults and checker FSM encoding for the flappy game.
package flappy_pkg;

    localparam int unsigned SCREEN_H_DEF  = 120;
    localparam int unsigned BIRD_X_DEF    = 40;
    localparam int unsigned BIRD_SIZE_DEF = 4;
    localparam int unsigned WALL_W_DEF    = 10;
    localparam int unsigned GAP_H_DEF     = 40;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StSnap   = 2'd1,
        StCheck  = 2'd2,
        StReport = 2'd3
    } state_e;

endpackage

// File: rtl/collision_detect_if.sv
// Frame-check request and result signals between game controller and collision checker.
interface collision_detect_if;

    logic       frame_tick;
    logic       enable;
    logic       clear;
    logic [6:0] bird_y;
    logic [7:0] wall_x;
    logic [6:0] gap_y;
    logic       collision;
    logic       collision_pulse;
    logic [7:0] score;
    logic       busy;
    logic       done;

    modport master (
        output frame_tick, enable, clear, bird_y, wall_x, gap_y,
        input  collision, collision_pulse, score, busy, done
    );

    modport slave (
        input  frame_tick, enable, clear, bird_y, wall_x, gap_y,
        output collision, collision_pulse, score, busy, done
    );

endinterface

// File: rtl/score_counter.sv
// Saturating walls-passed counter; a wall counts once until the wall wraps back to the right.
module score_counter (
    input  logic       clk,
    input  logic       resetn,
    input  logic       i_clear,
    input  logic       i_update,
    input  logic       i_hit,
    input  logic       i_hold,
    input  logic       i_wall_past,
    input  logic [7:0] i_wall_x,
    output logic [7:0] o_score
);

    logic [7:0] r_score;
    logic [7:0] r_prev_wall_x;
    logic       r_passed;

    logic w_wrap;
    logic w_passed_kept;
    logic w_inc;

    // A wall further right than last time is a fresh wall, so re-arm the passed flag.
    assign w_wrap        = i_wall_x > r_prev_wall_x;
    assign w_passed_kept = r_passed & ~w_wrap;
    assign w_inc         = i_wall_past & ~i_hit & ~w_passed_kept & ~i_hold;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_score       <= 8'd0;
            r_prev_wall_x <= 8'd0;
            r_passed      <= 1'b0;
        end else if (i_clear) begin
            r_score  <= 8'd0;
            r_passed <= 1'b0;
        end else if (i_update) begin
            r_prev_wall_x <= i_wall_x;
            r_passed      <= w_passed_kept | w_inc;
            if (w_inc && (r_score != 8'hff)) begin
                r_score <= r_score + 8'd1;
            end
        end
    end

    assign o_score = r_score;

endmodule

// File: rtl/collision_detect.sv
// Per-frame bird/wall collision checker: snapshot, evaluate, report, with sticky hit and score.
module collision_detect
    import flappy_pkg::*;
#(
    parameter int unsigned SCREEN_H  = SCREEN_H_DEF,
    parameter int unsigned BIRD_X    = BIRD_X_DEF,
    parameter int unsigned BIRD_SIZE = BIRD_SIZE_DEF,
    parameter int unsigned WALL_W    = WALL_W_DEF,
    parameter int unsigned GAP_H     = GAP_H_DEF
) (
    input logic               clk,
    input logic               resetn,
    collision_detect_if.slave io_bus
);

    localparam logic [8:0] BirdLeft  = 9'(BIRD_X);
    localparam logic [8:0] BirdRight = 9'(BIRD_X + BIRD_SIZE - 1);
    localparam logic [8:0] WallSpan  = 9'(WALL_W - 1);
    localparam logic [7:0] BirdSpan  = 8'(BIRD_SIZE - 1);
    localparam logic [7:0] GapSpan   = 8'(GAP_H - 1);
    localparam logic [7:0] FloorRow  = 8'(SCREEN_H);

    state_e     r_state;
    logic [6:0] r_bird_y;
    logic [7:0] r_wall_x;
    logic [6:0] r_gap_y;
    logic       r_busy;
    logic       r_done;
    logic       r_collision;
    logic       r_collision_pulse;

    logic [8:0] w_wall_left;
    logic [8:0] w_wall_right;
    logic [7:0] w_bird_bot;
    logic [7:0] w_gap_bot;
    logic       w_x_overlap;
    logic       w_y_miss;
    logic       w_floor_hit;
    logic       w_hit;
    logic       w_wall_past;
    logic       w_update;
    logic [7:0] w_score;

    // Geometry works only on the snapshot, so input changes after SNAP have no effect.
    assign w_wall_left  = {1'b0, r_wall_x};
    assign w_wall_right = {1'b0, r_wall_x} + WallSpan;
    assign w_bird_bot   = {1'b0, r_bird_y} + BirdSpan;
    assign w_gap_bot    = {1'b0, r_gap_y} + GapSpan;

    assign w_x_overlap = (w_wall_left <= BirdRight) && (w_wall_right >= BirdLeft);
    assign w_y_miss    = ({1'b0, r_bird_y} < {1'b0, r_gap_y}) || (w_bird_bot > w_gap_bot);
    assign w_floor_hit = w_bird_bot >= FloorRow;
    assign w_hit       = (w_x_overlap && w_y_miss) || w_floor_hit;
    assign w_wall_past = w_wall_right < BirdLeft;
    assign w_update    = (r_state == StCheck);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state           <= StIdle;
            r_bird_y          <= 7'd0;
            r_wall_x          <= 8'd0;
            r_gap_y           <= 7'd0;
            r_busy            <= 1'b0;
            r_done            <= 1'b0;
            r_collision       <= 1'b0;
            r_collision_pulse <= 1'b0;
        end else begin
            r_done            <= 1'b0;
            r_collision_pulse <= 1'b0;
            if (io_bus.clear) begin
                r_state     <= StIdle;
                r_busy      <= 1'b0;
                r_collision <= 1'b0;
            end else begin
                unique case (r_state)
                    StIdle: begin
                        if (io_bus.frame_tick && io_bus.enable && !r_collision) begin
                            r_state <= StSnap;
                            r_busy  <= 1'b1;
                        end
                    end
                    StSnap: begin
                        r_bird_y <= io_bus.bird_y;
                        r_wall_x <= io_bus.wall_x;
                        r_gap_y  <= io_bus.gap_y;
                        r_state  <= StCheck;
                    end
                    // Result is registered on leaving CHECK so it is visible throughout REPORT.
                    StCheck: begin
                        r_state <= StReport;
                        r_done  <= 1'b1;
                        if (w_hit) begin
                            r_collision       <= 1'b1;
                            r_collision_pulse <= ~r_collision;
                        end
                    end
                    StReport: begin
                        r_state <= StIdle;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    score_counter u_score_counter (
        .clk        (clk),
        .resetn     (resetn),
        .i_clear    (io_bus.clear),
        .i_update   (w_update),
        .i_hit      (w_hit),
        .i_hold     (r_collision),
        .i_wall_past(w_wall_past),
        .i_wall_x   (r_wall_x),
        .o_score    (w_score)
    );

    assign io_bus.collision       = r_collision;
    assign io_bus.collision_pulse = r_collision_pulse;
    assign io_bus.score           = w_score;
    assign io_bus.busy            = r_busy;
    assign io_bus.done            = r_done;

endmodule

// File: tb/tb_collision_detect.sv
// Bench for collision_detect: event-scheduled reference model plus directed literal checks.
module tb_collision_detect;
    import flappy_pkg::*;

    logic clk = 1'b0;
    logic resetn;

    collision_detect_if bus ();

    collision_detect dut (
        .clk   (clk),
        .resetn(resetn),
        .io_bus(bus)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    bit chk_on      = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Spec geometry in plain integer arithmetic.
    function automatic bit judge_hit(input int b, input int w, input int g);
        bit xo, ym, fl;
        xo = (w <= int'(BIRD_X_DEF + BIRD_SIZE_DEF) - 1) && (w + int'(WALL_W_DEF) - 1 >= int'(BIRD_X_DEF));
        ym = (b < g) || (b + int'(BIRD_SIZE_DEF) - 1 > g + int'(GAP_H_DEF) - 1);
        fl = (b + int'(BIRD_SIZE_DEF) - 1) >= int'(SCREEN_H_DEF);
        return (xo && ym) || fl;
    endfunction

    function automatic bit judge_past(input int w);
        return (w + int'(WALL_W_DEF) - 1) < int'(BIRD_X_DEF);
    endfunction

    // Model: an accepted tick schedules a report two edges later; busy lasts until one edge after.
    int cyc        = 0;
    bit pend_valid = 1'b0;
    int pend_rep   = 0;
    bit p_hit, p_past;
    int p_wall;
    bit m_coll = 1'b0, m_pulse = 1'b0, m_done = 1'b0, m_passed = 1'b0;
    int m_score = 0, m_prev = 0;

    always @(posedge clk) begin
        cyc     <= cyc + 1;
        m_done  <= 1'b0;
        m_pulse <= 1'b0;
        if (!resetn) begin
            m_coll     <= 1'b0;
            m_score    <= 0;
            m_passed   <= 1'b0;
            m_prev     <= 0;
            pend_valid <= 1'b0;
        end else if (bus.clear) begin
            m_coll     <= 1'b0;
            m_score    <= 0;
            m_passed   <= 1'b0;
            pend_valid <= 1'b0;
        end else if (!pend_valid) begin
            if (bus.frame_tick && bus.enable && !m_coll) begin
                pend_valid <= 1'b1;
                pend_rep   <= cyc + 2;
                p_hit      <= judge_hit(int'(bus.bird_y), int'(bus.wall_x), int'(bus.gap_y));
                p_past     <= judge_past(int'(bus.wall_x));
                p_wall     <= int'(bus.wall_x);
            end
        end else if (cyc == pend_rep) begin
            m_done <= 1'b1;
            m_prev <= p_wall;
            if (p_hit) begin
                m_coll  <= 1'b1;
                m_pulse <= !m_coll;
            end
            if (p_wall > m_prev) begin
                m_passed <= 1'b0;
            end
            if (!p_hit && p_past && !m_coll && !(m_passed && !(p_wall > m_prev))) begin
                m_passed <= 1'b1;
                m_score  <= (m_score < 255) ? m_score + 1 : 255;
            end
        end else if (cyc == pend_rep + 1) begin
            pend_valid <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("model collision", int'(bus.collision), int'(m_coll));
            chk("model collision_pulse", int'(bus.collision_pulse), int'(m_pulse));
            chk("model score", int'(bus.score), m_score);
            chk("model busy", int'(bus.busy), int'(pend_valid));
            chk("model done", int'(bus.done), int'(m_done));
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Tick with given inputs, hold through SNAP, then scramble; returns in the CHECK cycle.
    task automatic start_tick(input int b, input int w, input int g);
        bus.bird_y     = 7'(b);
        bus.wall_x     = 8'(w);
        bus.gap_y      = 7'(g);
        bus.frame_tick = 1'b1;
        step(1);
        bus.frame_tick = 1'b0;
        step(1);
        bus.bird_y = 7'($urandom_range(0, 119));
        bus.wall_x = 8'($urandom_range(0, 159));
        bus.gap_y  = 7'($urandom_range(0, 80));
    endtask

    task automatic do_tick(input int b, input int w, input int g);
        start_tick(b, w, g);
        step(2);
    endtask

    task automatic pulse_clear();
        bus.clear = 1'b1;
        step(1);
        bus.clear = 1'b0;
    endtask

    int exp_scores[5] = '{0, 1, 1, 1, 2};
    int walls[5]      = '{31, 29, 20, 159, 29};

    initial begin
        resetn         = 1'b0;
        bus.frame_tick = 1'b0;
        bus.enable     = 1'b1;
        bus.clear      = 1'b0;
        bus.bird_y     = 7'd0;
        bus.wall_x     = 8'd0;
        bus.gap_y      = 7'd0;
        step(1);
        chk_on = 1'b1;
        step(1);
        chk("reset collision", int'(bus.collision), 0);
        chk("reset score", int'(bus.score), 0);
        chk("reset busy", int'(bus.busy), 0);
        resetn = 1'b1;
        step(1);

        // Safe bird, wall far right.
        start_tick(50, 100, 40);
        step(1);
        chk("safe done at tick+3", int'(bus.done), 1);
        chk("safe collision", int'(bus.collision), 0);
        chk("safe score", int'(bus.score), 0);
        step(1);
        chk("safe done drops", int'(bus.done), 0);

        // Wall overlaps bird, bird above the gap.
        start_tick(30, 38, 40);
        step(1);
        chk("hit collision at tick+3", int'(bus.collision), 1);
        chk("hit pulse", int'(bus.collision_pulse), 1);
        step(1);
        chk("hit pulse one cycle", int'(bus.collision_pulse), 0);
        chk("hit sticky", int'(bus.collision), 1);
        step(3);
        chk("hit still sticky", int'(bus.collision), 1);

        pulse_clear();
        chk("clear collision", int'(bus.collision), 0);

        // Floor hit only.
        do_tick(117, 150, 100);
        chk("floor collision", int'(bus.collision), 1);

        // Clear wins over a simultaneous tick.
        bus.clear      = 1'b1;
        bus.frame_tick = 1'b1;
        step(1);
        bus.clear      = 1'b0;
        bus.frame_tick = 1'b0;
        chk("clear+tick collision", int'(bus.collision), 0);
        chk("clear+tick score", int'(bus.score), 0);
        chk("clear+tick busy", int'(bus.busy), 0);
        step(1);
        chk("clear+tick busy stays", int'(bus.busy), 0);

        // Passing walls.
        for (int i = 0; i < 5; i++) begin
            do_tick(50, walls[i], 40);
            chk("pass score", int'(bus.score), exp_scores[i]);
        end

        // Enable low blocks a new check.
        bus.enable     = 1'b0;
        bus.frame_tick = 1'b1;
        step(1);
        bus.frame_tick = 1'b0;
        chk("disabled busy", int'(bus.busy), 0);
        step(3);
        bus.enable = 1'b1;

        // Enable dropping mid-check lets it finish.
        bus.bird_y     = 7'd50;
        bus.wall_x     = 8'd100;
        bus.gap_y      = 7'd40;
        bus.frame_tick = 1'b1;
        step(1);
        bus.frame_tick = 1'b0;
        bus.enable     = 1'b0;
        step(2);
        chk("in-flight done", int'(bus.done), 1);
        step(1);
        bus.enable = 1'b1;

        // Saturation: alternate a wrapped wall with a passed wall.
        for (int i = 0; i < 260; i++) begin
            do_tick(50, 159, 40);
            do_tick(50, 29, 40);
        end
        chk("score saturates", int'(bus.score), 255);

        do_tick(30, 38, 40);
        chk("sat hit collision", int'(bus.collision), 1);
        chk("sat hit score held", int'(bus.score), 255);
        bus.frame_tick = 1'b1;
        step(1);
        bus.frame_tick = 1'b0;
        chk("blocked by collision", int'(bus.busy), 0);

        // Reset during CHECK.
        pulse_clear();
        do_tick(50, 29, 40);
        start_tick(30, 38, 40);
        resetn = 1'b0;
        step(1);
        chk("midreset busy", int'(bus.busy), 0);
        chk("midreset done", int'(bus.done), 0);
        chk("midreset collision", int'(bus.collision), 0);
        chk("midreset pulse", int'(bus.collision_pulse), 0);
        chk("midreset score", int'(bus.score), 0);
        resetn = 1'b1;
        step(3);
        chk("post reset no done", int'(bus.done), 0);
        chk("post reset collision", int'(bus.collision), 0);

        step(2);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/collision_detect.md
COLLISION_DETECT -- requirements
Module: collision_detect

Interface
REQ-001 Parameter SCREEN_H, default 120: playfield height in pixels.
REQ-002 Parameter BIRD_X, default 40: fixed left column of bird sprite.
REQ-003 Parameter BIRD_SIZE, default 4: bird sprite width and height in pixels.
REQ-004 Parameter WALL_W, default 10: wall width in pixels.
REQ-005 Parameter GAP_H, default 40: vertical gap height in pixels.
REQ-006 Reset and clock SHALL be: reset resetn, synchronous, active-low; clock clk.
REQ-007 clk  input  1  system clock.
REQ-008 resetn  input  1  synchronous active-low reset.
REQ-009 frame_tick  input  1  one-cycle pulse per frame, requests a check.
REQ-010 enable  input  1  game running; checks only when high.
REQ-011 clear  input  1  new-game pulse; clears collision and score.
REQ-012 bird_y  input  7  bird top row, 0..119.
REQ-013 wall_x  input  8  wall left column, 0..159.
REQ-014 gap_y  input  7  gap top row.
REQ-015 collision  output  1  sticky hit flag, drives the game controller's touched/collision input.
REQ-016 collision_pulse  output  1  one-cycle pulse when collision rises.
REQ-017 score  output  8  walls passed, saturating.
REQ-018 busy  output  1  check in progress.
REQ-019 done  output  1  one-cycle pulse at end of each check.

Function
REQ-020 FSM states SHALL be IDLE, SNAP, CHECK, REPORT; IDLE->SNAP on frame_tick & enable & !clear & !collision; SNAP->CHECK->REPORT->IDLE unconditionally.
REQ-021 SNAP SHALL register bird_y, wall_x, gap_y; inputs SHALL be ignored after SNAP.
REQ-022 busy SHALL be high in SNAP, CHECK, REPORT; frame_tick while busy SHALL be ignored (no queueing).
REQ-023 X-overlap SHALL be wall_x <= BIRD_X+BIRD_SIZE-1 AND wall_x+WALL_W-1 >= BIRD_X, computed at 9 bits.
REQ-024 Y-miss SHALL be bird_y < gap_y OR bird_y+BIRD_SIZE-1 > gap_y+GAP_H-1, computed at 8 bits.
REQ-025 Floor hit SHALL be bird_y+BIRD_SIZE-1 >= SCREEN_H.
REQ-026 Hit = (X-overlap AND Y-miss) OR floor hit; evaluated in CHECK, registered.
REQ-027 In REPORT: collision set if hit; done pulses; collision_pulse pulses iff collision was 0 and hit is 1.
REQ-028 Latency: collision/done visible 3 cycles after the frame_tick cycle.
REQ-029 collision SHALL stay 1 until clear or reset.
REQ-030 Passed flag SHALL be set in REPORT when wall_x+WALL_W-1 < BIRD_X, no hit, flag clear; score increments by 1 at that moment.
REQ-031 Passed flag SHALL clear when snapshot wall_x > previous snapshot wall_x (wall wrapped).
REQ-032 score SHALL saturate at 255 and SHALL not change while collision is 1.
REQ-033 clear SHALL zero collision, score, passed flag next cycle and return FSM to IDLE; clear beats simultaneous frame_tick.
REQ-034 enable low SHALL block new checks; an in-flight check completes.

Reset
REQ-035 On resetn low at any clock edge, including mid-check: state IDLE, all outputs 0, snapshots and passed flag 0.

Structure
REQ-036 SCREEN_H, BIRD_X, BIRD_SIZE, WALL_W, GAP_H defaults and FSM state encoding SHALL live in shared package flappy_pkg.
REQ-037 Saturating counter with passed flag SHALL be sub-module score_counter.

Verification
REQ-038 Reset; tick, bird_y=50, wall_x=100, gap_y=40 -> collision 0, score 0, done at tick+3.
REQ-039 Tick, wall_x=38, bird_y=30, gap_y=40 -> collision 1 at tick+3, collision_pulse exactly one cycle.
REQ-040 Tick, bird_y=117, wall_x=150 -> floor collision 1.
REQ-041 Safe bird, ticks wall_x=31,29,20,159,29 -> score 0,1,1,1,2.
REQ-042 collision=1; clear and frame_tick same cycle -> collision 0, score 0, busy stays 0.
REQ-043 resetn low during CHECK -> next cycle all outputs 0, state IDLE, no done.
